// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared load-type codes, MEM-stage FSM states and byte-mask constant.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_W    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_B    = 3'b011;
  localparam logic [2:0] LD_HU   = 3'b100;
  localparam logic [2:0] LD_BU   = 3'b101;
  localparam logic [2:0] LD_FW   = 3'b110;

  localparam logic [31:0] BWEB_NONE = 32'hffff_ffff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_access_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Shifts the raw load word to the addressed byte and sign/zero-extends.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [31:0] w_sh;

  always_comb begin
    // Lanes above the word's top byte shift in as zero, so misaligned halves see 0.
    w_sh = rdata >> {offset, 3'b000};
    case (load_type)
      LD_B:    result = {{24{w_sh[7]}}, w_sh[7:0]};
      LD_BU:   result = {24'h0, w_sh[7:0]};
      LD_H:    result = {{16{w_sh[15]}}, w_sh[15:0]};
      LD_HU:   result = {16'h0, w_sh[15:0]};
      default: result = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_access
// Purpose  : MEM-stage data-memory handshake with timeout, plus MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] store_data,
  input  logic [31:0] dm_bweb,
  input  logic [2:0]  is_load_mem,
  input  logic [5:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  input  logic        float_wb_en_mem,
  output logic        dm_req,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_bweb_o,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [5:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic        float_wb_en_wb,
  output logic        bus_err
);

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  mem_state_t  r_state;
  mem_state_t  w_state_next;
  logic [7:0]  r_cnt;
  logic        w_load;
  logic        w_store;
  logic        w_op;
  logic        w_tmo_hit;
  logic        w_tmo;
  logic        w_req;
  logic        w_stall;
  logic [31:0] w_aligned;
  logic [31:0] w_load_result;
  logic [31:0] r_wb_data;
  logic [5:0]  r_rd_addr_wb;
  logic        r_wb_en_wb;
  logic        r_float_wb_en_wb;
  logic        r_bus_err;

  // A load wins when both a load type and a write mask are presented.
  assign w_load    = (is_load_mem != LD_NONE);
  assign w_store   = (dm_bweb != BWEB_NONE) && !w_load;
  assign w_op      = w_load || w_store;
  assign w_tmo_hit = (r_cnt == c_tmo_last);

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_op) begin
          w_req = 1'b1;
          if (!dm_gnt) begin
            w_stall      = 1'b1;
            w_state_next = REQ;
          end else if (w_load) begin
            w_stall      = 1'b1;
            w_state_next = WAIT;
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (dm_gnt) begin
          if (w_load) begin
            w_stall      = 1'b1;
            w_state_next = WAIT;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          w_state_next = IDLE;
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Restart the count on every entry into REQ or WAIT, including REQ -> WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_state_next != IDLE && w_state_next != r_state) begin
      r_cnt <= 8'd0;
    end else if (r_state != IDLE) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else if (w_tmo) begin
      r_bus_err <= 1'b1;
    end
  end

  load_align u_load_align (
    .rdata     (dm_rdata),
    .offset    (alu_out_mem[1:0]),
    .load_type (is_load_mem),
    .result    (w_aligned)
  );

  assign w_load_result = w_tmo ? 32'h0 : w_aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data        <= 32'h0;
      r_rd_addr_wb     <= 6'h0;
      r_wb_en_wb       <= 1'b0;
      r_float_wb_en_wb <= 1'b0;
    end else if (!w_stall) begin
      r_wb_data        <= w_load ? w_load_result : alu_out_mem;
      r_rd_addr_wb     <= rd_addr_mem;
      r_wb_en_wb       <= wb_en_mem;
      r_float_wb_en_wb <= float_wb_en_mem;
    end else begin
      r_wb_en_wb       <= 1'b0;
      r_float_wb_en_wb <= 1'b0;
    end
  end

  assign dm_req         = w_req && !rst;
  assign dm_addr        = alu_out_mem[31:2];
  assign dm_wdata       = store_data;
  assign dm_bweb_o      = (w_req && w_store) ? dm_bweb : BWEB_NONE;
  assign mem_stall      = w_stall;
  assign wb_data        = r_wb_data;
  assign rd_addr_wb     = r_rd_addr_wb;
  assign wb_en_wb       = r_wb_en_wb;
  assign float_wb_en_wb = r_float_wb_en_wb;
  assign bus_err        = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_access
// Purpose  : Directed self-checking bench for the MEM stage / MEM-WB register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_access;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out_mem;
  logic [31:0] store_data;
  logic [31:0] dm_bweb;
  logic [2:0]  is_load_mem;
  logic [5:0]  rd_addr_mem;
  logic        wb_en_mem;
  logic        float_wb_en_mem;
  logic        dm_req;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_bweb_o;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic [31:0] wb_data;
  logic [5:0]  rd_addr_wb;
  logic        wb_en_wb;
  logic        float_wb_en_wb;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] c_ones = 32'hffff_ffff;

  typedef struct {
    logic [2:0]  ld;
    logic [31:0] addr;
    logic [31:0] bweb;
    logic [31:0] rdata;
    logic [5:0]  rd;
    logic        wb_en;
    logic        fwb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  mem_wb_access #(.TIMEOUT(255)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_out_mem     (alu_out_mem),
    .store_data      (store_data),
    .dm_bweb         (dm_bweb),
    .is_load_mem     (is_load_mem),
    .rd_addr_mem     (rd_addr_mem),
    .wb_en_mem       (wb_en_mem),
    .float_wb_en_mem (float_wb_en_mem),
    .dm_req          (dm_req),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_bweb_o       (dm_bweb_o),
    .dm_gnt          (dm_gnt),
    .dm_rvalid       (dm_rvalid),
    .dm_rdata        (dm_rdata),
    .mem_stall       (mem_stall),
    .wb_data         (wb_data),
    .rd_addr_wb      (rd_addr_wb),
    .wb_en_wb        (wb_en_wb),
    .float_wb_en_wb  (float_wb_en_wb),
    .bus_err         (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic go_idle();
    is_load_mem     = 3'b000;
    dm_bweb         = c_ones;
    dm_gnt          = 1'b0;
    dm_rvalid       = 1'b0;
    wb_en_mem       = 1'b0;
    float_wb_en_mem = 1'b0;
  endtask

  // One op with an immediate grant; loads see rvalid the following cycle.
  task automatic apply_vec(input int i, input vec_t v);
    is_load_mem     = v.ld;
    alu_out_mem     = v.addr;
    dm_bweb         = v.bweb;
    store_data      = 32'hA5A5_0000;
    rd_addr_mem     = v.rd;
    wb_en_mem       = v.wb_en;
    float_wb_en_mem = v.fwb;
    dm_rvalid       = 1'b0;
    dm_gnt          = (v.ld != 3'b000) || (v.bweb != c_ones);
    @(negedge clk);
    if (v.ld != 3'b000) begin
      check1($sformatf("v%0d_req", i), dm_req, 1'b1);
      check1($sformatf("v%0d_stall1", i), mem_stall, 1'b1);
      check($sformatf("v%0d_addr", i), {2'b00, dm_addr}, {2'b00, v.addr[31:2]});
      check($sformatf("v%0d_bweb_o", i), dm_bweb_o, c_ones);
      @(posedge clk); #1;
      check1($sformatf("v%0d_bubble", i), wb_en_wb, 1'b0);
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = v.rdata;
      @(negedge clk);
      check1($sformatf("v%0d_stall2", i), mem_stall, 1'b0);
      check1($sformatf("v%0d_req_wait", i), dm_req, 1'b0);
      @(posedge clk); #1;
    end else if (v.bweb != c_ones) begin
      check1($sformatf("v%0d_st_req", i), dm_req, 1'b1);
      check1($sformatf("v%0d_st_stall", i), mem_stall, 1'b0);
      check($sformatf("v%0d_st_bweb_o", i), dm_bweb_o, v.bweb);
      @(posedge clk); #1;
    end else begin
      check1($sformatf("v%0d_alu_req", i), dm_req, 1'b0);
      check1($sformatf("v%0d_alu_stall", i), mem_stall, 1'b0);
      check($sformatf("v%0d_alu_bweb_o", i), dm_bweb_o, c_ones);
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_wb_data", i), wb_data, v.exp);
    check($sformatf("v%0d_rd", i), {26'h0, rd_addr_wb}, {26'h0, v.rd});
    check1($sformatf("v%0d_wb_en", i), wb_en_wb, v.wb_en);
    check1($sformatf("v%0d_fwb_en", i), float_wb_en_wb, v.fwb);
    go_idle();
  endtask

  initial begin
    int n;
    //              ld      addr          bweb          rdata         rd     we    fwe   expected
    vecs[0]  = '{3'b011, 32'h0000_1003, c_ones,        32'h80AA_BBCC, 6'd1,  1'b1, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{3'b100, 32'h0000_2002, c_ones,        32'h8001_1234, 6'd2,  1'b1, 1'b0, 32'h0000_8001};
    vecs[2]  = '{3'b010, 32'h0000_2002, c_ones,        32'h8001_1234, 6'd3,  1'b1, 1'b0, 32'hFFFF_8001};
    vecs[3]  = '{3'b000, 32'h0000_1234, c_ones,        32'h0,         6'd4,  1'b1, 1'b0, 32'h0000_1234};
    vecs[4]  = '{3'b001, 32'h0000_4000, c_ones,        32'hDEAD_BEEF, 6'd5,  1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{3'b101, 32'h0000_0001, c_ones,        32'h1234_F678, 6'd6,  1'b1, 1'b0, 32'h0000_00F6};
    vecs[6]  = '{3'b011, 32'h0000_0001, c_ones,        32'h1234_F678, 6'd7,  1'b1, 1'b0, 32'hFFFF_FFF6};
    vecs[7]  = '{3'b010, 32'h0000_0003, c_ones,        32'hFF12_3456, 6'd8,  1'b1, 1'b0, 32'h0000_00FF};
    vecs[8]  = '{3'b110, 32'h0000_0008, c_ones,        32'h3F80_0000, 6'd33, 1'b0, 1'b1, 32'h3F80_0000};
    vecs[9]  = '{3'b111, 32'h0000_000C, c_ones,        32'hCAFE_F00D, 6'd9,  1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[10] = '{3'b001, 32'h0000_0012, c_ones,        32'hAABB_CCDD, 6'd10, 1'b1, 1'b0, 32'h0000_AABB};
    vecs[11] = '{3'b010, 32'h0000_0010, c_ones,        32'h1234_FFFE, 6'd11, 1'b1, 1'b0, 32'hFFFF_FFFE};
    vecs[12] = '{3'b000, 32'h0000_0104, 32'hFFFF_FF00, 32'h0,         6'd0,  1'b0, 1'b0, 32'h0000_0104};
    vecs[13] = '{3'b001, 32'h0000_0030, 32'h0000_0000, 32'h1122_3344, 6'd12, 1'b1, 1'b0, 32'h1122_3344};

    rst         = 1'b1;
    alu_out_mem = 32'h0;
    store_data  = 32'h0;
    rd_addr_mem = 6'h0;
    dm_rdata    = 32'h0;
    go_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_rd", {26'h0, rd_addr_wb}, 32'h0);
    check1("rst_wb_en", wb_en_wb, 1'b0);
    check1("rst_fwb_en", float_wb_en_wb, 1'b0);
    check1("rst_bus_err", bus_err, 1'b0);
    check1("rst_req", dm_req, 1'b0);
    check1("rst_stall", mem_stall, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) apply_vec(i, vecs[i]);

    // SH with grant arriving on the fourth request cycle.
    alu_out_mem = 32'h0000_3002;
    dm_bweb     = 32'h0000_ffff;
    store_data  = 32'h5678_0000;
    rd_addr_mem = 6'd0;
    wb_en_mem   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dm_gnt = (c == 3);
      @(negedge clk);
      check1($sformatf("sh_req_c%0d", c), dm_req, 1'b1);
      check1($sformatf("sh_stall_c%0d", c), mem_stall, (c < 3));
      check($sformatf("sh_bweb_o_c%0d", c), dm_bweb_o, 32'h0000_ffff);
      check($sformatf("sh_addr_c%0d", c), {2'b00, dm_addr}, 32'h0000_0C00);
      check($sformatf("sh_wdata_c%0d", c), dm_wdata, 32'h5678_0000);
      @(posedge clk); #1;
      check1($sformatf("sh_wb_en_c%0d", c), wb_en_wb, 1'b0);
    end
    check("sh_wb_data", wb_data, 32'h0000_3002);
    go_idle();
    @(negedge clk);
    check1("sh_after_req", dm_req, 1'b0);
    check1("sh_after_stall", mem_stall, 1'b0);
    @(posedge clk); #1;

    // LW granted but never answered: forced completion after TIMEOUT stalls.
    is_load_mem = 3'b001;
    alu_out_mem = 32'h0000_0040;
    rd_addr_mem = 6'd7;
    wb_en_mem   = 1'b1;
    dm_gnt      = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!mem_stall) break;
      if (n == 100) check1("tmo_err_pending", bus_err, 1'b0);
      n++;
      @(posedge clk); #1;
      dm_gnt = 1'b0;
    end
    check("tmo_stall_cycles", n, 32'd255);
    @(posedge clk); #1;
    check("tmo_wb_data", wb_data, 32'h0);
    check1("tmo_bus_err", bus_err, 1'b1);
    check1("tmo_wb_en", wb_en_wb, 1'b1);
    go_idle();
    apply_vec(100, '{3'b000, 32'h0000_0055, c_ones, 32'h0, 6'd13, 1'b1, 1'b0, 32'h0000_0055});
    check1("tmo_err_sticky", bus_err, 1'b1);

    // Async reset while waiting for rvalid.
    is_load_mem = 3'b001;
    alu_out_mem = 32'h0000_0020;
    rd_addr_mem = 6'd14;
    wb_en_mem   = 1'b1;
    dm_gnt      = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    @(negedge clk);
    check1("rstw_stall_wait", mem_stall, 1'b1);
    #2;
    rst = 1'b1;
    go_idle();
    #1;
    check1("rstw_req", dm_req, 1'b0);
    check1("rstw_stall", mem_stall, 1'b0);
    check("rstw_wb_data", wb_data, 32'h0);
    check("rstw_rd", {26'h0, rd_addr_wb}, 32'h0);
    check1("rstw_wb_en", wb_en_wb, 1'b0);
    check1("rstw_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_vec(200, '{3'b001, 32'h0000_0024, c_ones, 32'h0123_4567, 6'd15, 1'b1, 1'b0, 32'h0123_4567});
    check1("rstw_err_clear", bus_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_access.md
Name: mem_wb_access

Overview:
- Memory-stage responder and MEM/WB register for the 5-stage RV32 core.
- Consumes the EX/MEM outputs: registered address/ALU result, lane-shifted store data, active-low byte write mask and load type.
- Drives a variable-latency data-memory handshake and stalls the pipeline until the access completes.
- Aligns and sign/zero-extends load data, then registers results into the WB stage (rd, write enables, forward data).

Parameters:
TIMEOUT, 255, max cycles waited in REQ/WAIT before forced completion with bus error.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_out_mem  in  32  ALU/CSR/FPU result; byte address for loads/stores
store_data  in  32  store data, already shifted to byte lane
dm_bweb  in  32  active-low bit write mask; 32'hffff_ffff = not a store
is_load_mem  in  3  load type (encoding in package)
rd_addr_mem  in  6  destination register (bit 5 = float file)
wb_en_mem  in  1  integer writeback enable
float_wb_en_mem  in  1  float writeback enable
dm_req  out  1  memory request
dm_addr  out  30  word address = alu_out_mem[31:2]
dm_wdata  out  32  equals store_data
dm_bweb_o  out  32  equals dm_bweb during store request, else all-ones
dm_gnt  in  1  request accepted (same-cycle or later)
dm_rvalid  in  1  load data valid
dm_rdata  in  32  raw load word
mem_stall  out  1  hold IF..MEM; combinational
wb_data  out  32  WB/forward data (fw_from_wb)
rd_addr_wb  out  6  registered rd
wb_en_wb  out  1  registered integer write enable
float_wb_en_wb  out  1  registered float write enable
bus_err  out  1  sticky timeout flag

Behaviour:
Operation decode:
- load = is_load_mem != 0
- store = dm_bweb != all-ones
- Both set: treated as a load; dm_bweb_o stays all-ones.

Load encoding:
- 001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU, 110 FLW (as LW).
- 111 is reserved and treated as LW.

FSM states: IDLE, REQ, WAIT.
- IDLE, no op: dm_req=0, mem_stall=0; stay.
- IDLE, op: dm_req=1.
  - store & dm_gnt: complete, stall=0, stay IDLE.
  - load & dm_gnt: stall=1, go WAIT.
  - no gnt: stall=1, go REQ.
- REQ: dm_req=1, stall=1 until completion.
  - store & gnt: stall=0 this cycle, go IDLE.
  - load & gnt: go WAIT.
- WAIT: dm_req=0, stall = !dm_rvalid.
  - dm_rvalid: capture aligned data, go IDLE.
- Same-cycle gnt+rvalid in IDLE/REQ for a load: not permitted by memory protocol; ignore rvalid outside WAIT.

Timing and latency:
- Minimum load latency: 1 stall cycle (gnt in IDLE, rvalid next cycle).
- Minimum store latency: 0 stall cycles.

Timeout:
- 8-bit counter cleared on entry to REQ/WAIT; increments each cycle in those states.
- At count == TIMEOUT-1 without completion:
  - force completion (stall=0, go IDLE);
  - load data = 0;
  - bus_err<=1 (sticky until rst).

WB register (updates every clock):
- mem_stall=0: wb_data, rd_addr_wb, wb_en_wb and float_wb_en_wb take the stage result.
  - Load: wb_data = aligned data.
  - Otherwise: wb_data = alu_out_mem.
- mem_stall=1: wb_en_wb <= 0 and float_wb_en_wb <= 0 (bubble); wb_data and rd_addr_wb hold.

Load alignment:
- sh = dm_rdata >> (8*alu_out_mem[1:0]).
- LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
- LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
- LW/FLW: sh.
- Misaligned upper lanes read as 0 (e.g. LH at offset 3 sign-extends {8'h0, byte3} as a 16-bit value).

Reset (any time, including mid-access):
- State IDLE, counter 0, dm_req=0.
- wb_data=0, rd_addr_wb=0, wb_en_wb=0, float_wb_en_wb=0, bus_err=0.
- mem_stall=0 after reset, assuming no op is presented.

Decomposition:
- Package mem_pkg: load-type localparams (LD_NONE, LD_W, LD_H, LD_B, LD_HU, LD_BU, LD_FW), state enum mem_state_t {IDLE, REQ, WAIT}, BWEB_NONE = 32'hffff_ffff.
- Sub-module load_align (combinational: rdata, offset, load type -> 32-bit result), instantiated once; kept separate for unit testing.

Test Plan:
- LB at addr 0x1003, memory gnt immediate, rvalid next cycle with rdata 0x80AA_BBCC -> 1 stall cycle; wb_data=0xFFFF_FF80; wb_en_wb=1 one cycle later.
- LHU addr 0x2002, rdata 0x8001_1234 -> wb_data=0x0000_8001. LH with same inputs -> 0xFFFF_8001.
- SH addr 0x3002, dm_bweb=0x0000_ffff, gnt delayed 3 cycles -> dm_req high 4 cycles, mem_stall high 3 cycles, dm_bweb_o=0x0000_ffff, dm_addr=0xC00; WB gets 3 bubbles, then rd write disabled.
- ALU op, no memory access, alu_out_mem=0x1234 -> no dm_req, no stall; wb_data=0x1234 next edge.
- Load with gnt but no rvalid for TIMEOUT cycles -> forced completion, wb_data=0, bus_err=1 and stays 1; next op proceeds normally.
- rst asserted during WAIT -> dm_req=0 and state IDLE immediately; outputs zero; a subsequent LW returns correct data.
